// File: rtl/i2c_reg_arbiter_if.sv
// Bundle of i2c slave register-port, host req/ack and event-report signals.
// Latency: none, wires only.
// Backpressure: host side waits on host_ack; the i2c side is never stalled.
interface i2c_reg_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
);
  // i2c slave register port
  logic                  i2c_write_en;
  logic [ADDR_WIDTH-1:0] i2c_reg_addr;
  logic [DATA_WIDTH-1:0] i2c_wdata;
  logic [DATA_WIDTH-1:0] i2c_rdata;
  logic                  i2c_busy;
  logic                  i2c_done;
  // local host port
  logic                  host_req;
  logic                  host_we;
  logic [ADDR_WIDTH-1:0] host_addr;
  logic [DATA_WIDTH-1:0] host_wdata;
  logic                  host_ack;
  logic [DATA_WIDTH-1:0] host_rdata;
  logic                  host_err;
  // event reports to local logic
  logic                  upd_valid;
  logic [ADDR_WIDTH-1:0] upd_addr;
  logic                  xfer_done;
  logic                  xfer_dirty;

  // arbiter side
  modport slave (
    input  i2c_write_en, i2c_reg_addr, i2c_wdata, i2c_busy, i2c_done,
    input  host_req, host_we, host_addr, host_wdata,
    output i2c_rdata, host_ack, host_rdata, host_err,
    output upd_valid, upd_addr, xfer_done, xfer_dirty
  );

  // environment side (i2c slave + host + event consumer)
  modport master (
    output i2c_write_en, i2c_reg_addr, i2c_wdata, i2c_busy, i2c_done,
    output host_req, host_we, host_addr, host_wdata,
    input  i2c_rdata, host_ack, host_rdata, host_err,
    input  upd_valid, upd_addr, xfer_done, xfer_dirty
  );
endinterface

// File: rtl/i2c_reg_arbiter.sv
// Register bank shared by an i2c slave register port (always wins) and a host req/ack port.
// Latency: i2c read 1 cycle, i2c write commits same edge; host ack on 2nd edge after req, +1 per collision.
// Backpressure: i2c never stalls; host is deferred on same-cycle i2c writes and optionally held while i2c_busy.
module i2c_reg_arbiter #(
  parameter int          ADDR_WIDTH   = 8,
  parameter int          DATA_WIDTH   = 16,
  parameter int          NUM_REGS     = 16,
  parameter logic [31:0] RO_MASK      = 32'h0,
  parameter int          HOST_LOCK    = 1,
  parameter int          LOCK_TIMEOUT = 4095
) (
  input  logic                clk,
  input  logic                reset,
  i2c_reg_arbiter_if.slave    bus
);

  localparam int CNT_W = (LOCK_TIMEOUT < 2) ? 1 : $clog2(LOCK_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOCKED = 2'd1,
    ST_ACCESS = 2'd2,
    ST_ACK    = 2'd3
  } state_t;

  // register storage
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  // host FSM state and latched request
  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] haddr_q, haddr_d;
  logic                  hwe_q, hwe_d;
  logic [DATA_WIDTH-1:0] hwdata_q, hwdata_d;
  logic                  host_ack_q, host_ack_d;
  logic                  host_err_q, host_err_d;
  logic [DATA_WIDTH-1:0] host_rdata_q, host_rdata_d;
  logic                  host_commit;

  // i2c-side outputs and edge detection
  logic [DATA_WIDTH-1:0] i2c_rdata_q, i2c_rdata_d;
  logic                  upd_valid_q, upd_valid_d;
  logic [ADDR_WIDTH-1:0] upd_addr_q, upd_addr_d;
  logic                  xfer_done_q, xfer_done_d;
  logic                  xfer_dirty_q, xfer_dirty_d;
  logic                  dirty_q, dirty_d;
  logic                  busy_dly_q, busy_dly_d;
  logic                  done_dly_q, done_dly_d;

  // decode helpers
  logic                  i2c_wr_ok;
  logic [DATA_WIDTH-1:0] i2c_rd_val;
  logic                  host_hit;
  logic [DATA_WIDTH-1:0] host_rd_val;
  logic                  done_rise;
  logic                  busy_rise;

  // i2c address decode: read mux (0 when out of range) and write qualification (in range, not RO)
  always_comb begin
    i2c_wr_ok  = 1'b0;
    i2c_rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (bus.i2c_reg_addr == ADDR_WIDTH'(i)) begin
        i2c_rd_val = regs_q[i];
        i2c_wr_ok  = bus.i2c_write_en && !RO_MASK[i];
      end
    end
  end

  // host address decode on the latched address: range hit and pre-write read value
  always_comb begin
    host_hit    = 1'b0;
    host_rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (haddr_q == ADDR_WIDTH'(i)) begin
        host_hit    = 1'b1;
        host_rd_val = regs_q[i];
      end
    end
  end

  // register next state: only the i2c write and the host commit may modify a register;
  // the FSM never commits in a cycle with i2c_write_en, so the two never coincide
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (i2c_wr_ok && (bus.i2c_reg_addr == ADDR_WIDTH'(i))) begin
        regs_d[i] = bus.i2c_wdata;
      end else if (host_commit && (haddr_q == ADDR_WIDTH'(i))) begin
        regs_d[i] = hwdata_q;
      end
    end
  end

  // i2c read pipeline, write notification, and transfer-end / dirty tracking
  always_comb begin
    done_rise    = bus.i2c_done & ~done_dly_q;
    busy_rise    = bus.i2c_busy & ~busy_dly_q;
    busy_dly_d   = bus.i2c_busy;
    done_dly_d   = bus.i2c_done;
    i2c_rdata_d  = i2c_rd_val;
    upd_valid_d  = i2c_wr_ok;
    upd_addr_d   = i2c_wr_ok ? bus.i2c_reg_addr : upd_addr_q;
    xfer_done_d  = done_rise;
    xfer_dirty_d = done_rise & dirty_q;
    // a write landing on the same edge as a transfer boundary belongs to the new transfer
    dirty_d      = dirty_q;
    if (done_rise || busy_rise) begin
      dirty_d = 1'b0;
    end
    if (i2c_wr_ok) begin
      dirty_d = 1'b1;
    end
  end

  // host FSM: next state, latched request, ack/err/rdata and commit strobe
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    haddr_d      = haddr_q;
    hwe_d        = hwe_q;
    hwdata_d     = hwdata_q;
    host_ack_d   = 1'b0;
    host_err_d   = 1'b0;
    host_rdata_d = host_rdata_q;
    host_commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.host_req) begin
          haddr_d  = bus.host_addr;
          hwe_d    = bus.host_we;
          hwdata_d = bus.host_wdata;
          if (bus.host_we && (HOST_LOCK != 0) && bus.i2c_busy) begin
            state_d = ST_LOCKED;
            cnt_d   = '0;
          end else begin
            state_d = ST_ACCESS;
          end
        end
      end
      ST_LOCKED: begin
        if (!bus.i2c_busy) begin
          state_d = ST_ACCESS;
        end else if (cnt_q == CNT_W'(LOCK_TIMEOUT)) begin
          host_ack_d = 1'b1;
          host_err_d = 1'b1;
          state_d    = ST_ACK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ACCESS: begin
        if (!host_hit) begin
          host_ack_d   = 1'b1;
          host_err_d   = 1'b1;
          host_rdata_d = '0;
          state_d      = ST_ACK;
        end else if (hwe_q && bus.i2c_write_en) begin
          // i2c owns this edge; retry next cycle so the host value lands last
          state_d = ST_ACCESS;
        end else begin
          if (hwe_q) begin
            host_commit = 1'b1;
          end else begin
            host_rdata_d = host_rd_val;
          end
          host_ack_d = 1'b1;
          state_d    = ST_ACK;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // register bank storage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // host FSM and host output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      haddr_q      <= '0;
      hwe_q        <= 1'b0;
      hwdata_q     <= '0;
      host_ack_q   <= 1'b0;
      host_err_q   <= 1'b0;
      host_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      haddr_q      <= haddr_d;
      hwe_q        <= hwe_d;
      hwdata_q     <= hwdata_d;
      host_ack_q   <= host_ack_d;
      host_err_q   <= host_err_d;
      host_rdata_q <= host_rdata_d;
    end
  end

  // i2c-side output registers, edge-detect delay flops and dirty flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i2c_rdata_q  <= '0;
      upd_valid_q  <= 1'b0;
      upd_addr_q   <= '0;
      xfer_done_q  <= 1'b0;
      xfer_dirty_q <= 1'b0;
      dirty_q      <= 1'b0;
      busy_dly_q   <= 1'b0;
      done_dly_q   <= 1'b0;
    end else begin
      i2c_rdata_q  <= i2c_rdata_d;
      upd_valid_q  <= upd_valid_d;
      upd_addr_q   <= upd_addr_d;
      xfer_done_q  <= xfer_done_d;
      xfer_dirty_q <= xfer_dirty_d;
      dirty_q      <= dirty_d;
      busy_dly_q   <= busy_dly_d;
      done_dly_q   <= done_dly_d;
    end
  end

  assign bus.i2c_rdata  = i2c_rdata_q;
  assign bus.host_ack   = host_ack_q;
  assign bus.host_err   = host_err_q;
  assign bus.host_rdata = host_rdata_q;
  assign bus.upd_valid  = upd_valid_q;
  assign bus.upd_addr   = upd_addr_q;
  assign bus.xfer_done  = xfer_done_q;
  assign bus.xfer_dirty = xfer_dirty_q;

endmodule

// File: tb/tb_i2c_reg_arbiter.sv
// Directed bench for i2c_reg_arbiter: vector table of single accesses plus hand-written
// sequences for transfer events, collision, lock, lock timeout and mid-operation reset.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_i2c_reg_arbiter;
  localparam int AW = 8;
  localparam int DW = 16;

  localparam int OP_HW = 0;
  localparam int OP_HR = 1;
  localparam int OP_IW = 2;
  localparam int OP_IR = 3;

  typedef struct {
    int           op;
    logic [7:0]   addr;
    logic [15:0]  data;
    logic [15:0]  exp_dat;
    logic         exp_err;
    logic         exp_upd;
  } vec_t;

  localparam int NV = 18;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  i2c_reg_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  i2c_reg_arbiter #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .NUM_REGS     (16),
    .RO_MASK      (32'h1),
    .HOST_LOCK    (1),
    .LOCK_TIMEOUT (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // waits for host_ack, counting falling edges from lat0; drops host_req on seeing ack
  task automatic wait_ack(input int lat0, output int lat, output logic [15:0] rd, output logic err);
    lat = lat0;
    rd  = '0;
    err = 1'b0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      lat++;
      if (bus.host_ack) begin
        rd  = bus.host_rdata;
        err = bus.host_err;
        bus.host_req = 1'b0;
        return;
      end
    end
    lat = -1;
    bus.host_req = 1'b0;
  endtask

  task automatic host_op(input logic we, input logic [7:0] addr, input logic [15:0] wd,
                         output int lat, output logic [15:0] rd, output logic err);
    @(negedge clk);
    bus.host_req   = 1'b1;
    bus.host_we    = we;
    bus.host_addr  = addr;
    bus.host_wdata = wd;
    wait_ack(0, lat, rd, err);
  endtask

  task automatic i2c_wr(input logic [7:0] addr, input logic [15:0] wd,
                        output logic upd, output logic [7:0] uaddr);
    @(negedge clk);
    bus.i2c_write_en = 1'b1;
    bus.i2c_reg_addr = addr;
    bus.i2c_wdata    = wd;
    @(negedge clk);
    bus.i2c_write_en = 1'b0;
    upd   = bus.upd_valid;
    uaddr = bus.upd_addr;
  endtask

  task automatic i2c_rd(input logic [7:0] addr, output logic [15:0] d);
    @(negedge clk);
    bus.i2c_reg_addr = addr;
    @(negedge clk);
    d = bus.i2c_rdata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t        vecs [NV];
    vec_t        v;
    int          lat;
    logic [15:0] rd;
    logic        err;
    logic        upd;
    logic [7:0]  ua;
    logic        seen;

    vecs[0]  = '{OP_HR, 8'h03, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[1]  = '{OP_IR, 8'h03, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[2]  = '{OP_IW, 8'h02, 16'hBEEF, 16'h0000, 1'b0, 1'b1};
    vecs[3]  = '{OP_IR, 8'h02, 16'h0000, 16'hBEEF, 1'b0, 1'b0};
    vecs[4]  = '{OP_HR, 8'h02, 16'h0000, 16'hBEEF, 1'b0, 1'b0};
    vecs[5]  = '{OP_HW, 8'h07, 16'h5A5A, 16'h0000, 1'b0, 1'b0};
    vecs[6]  = '{OP_HR, 8'h07, 16'h0000, 16'h5A5A, 1'b0, 1'b0};
    vecs[7]  = '{OP_IW, 8'h00, 16'h1234, 16'h0000, 1'b0, 1'b0};
    vecs[8]  = '{OP_HR, 8'h00, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[9]  = '{OP_HW, 8'h00, 16'h1234, 16'h0000, 1'b0, 1'b0};
    vecs[10] = '{OP_IR, 8'h00, 16'h0000, 16'h1234, 1'b0, 1'b0};
    vecs[11] = '{OP_HW, 8'h20, 16'hFFFF, 16'h0000, 1'b1, 1'b0};
    vecs[12] = '{OP_HR, 8'h10, 16'h0000, 16'h0000, 1'b1, 1'b0};
    vecs[13] = '{OP_IW, 8'h11, 16'h9999, 16'h0000, 1'b0, 1'b0};
    vecs[14] = '{OP_IR, 8'h11, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[15] = '{OP_HR, 8'h0F, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[16] = '{OP_HW, 8'h0F, 16'hCAFE, 16'h0000, 1'b0, 1'b0};
    vecs[17] = '{OP_IR, 8'h0F, 16'h0000, 16'hCAFE, 1'b0, 1'b0};

    bus.i2c_write_en = 1'b0;
    bus.i2c_reg_addr = '0;
    bus.i2c_wdata    = '0;
    bus.i2c_busy     = 1'b0;
    bus.i2c_done     = 1'b0;
    bus.host_req     = 1'b0;
    bus.host_we      = 1'b0;
    bus.host_addr    = '0;
    bus.host_wdata   = '0;

    // reset state
    repeat (2) @(negedge clk);
    check("rst i2c_rdata",  32'(bus.i2c_rdata), 32'h0);
    check("rst host_ack",   32'(bus.host_ack), 32'h0);
    check("rst host_err",   32'(bus.host_err), 32'h0);
    check("rst host_rdata", 32'(bus.host_rdata), 32'h0);
    check("rst upd_valid",  32'(bus.upd_valid), 32'h0);
    check("rst upd_addr",   32'(bus.upd_addr), 32'h0);
    check("rst xfer_done",  32'(bus.xfer_done), 32'h0);
    check("rst xfer_dirty", 32'(bus.xfer_dirty), 32'h0);
    reset = 1'b1;
    @(negedge clk);

    // single-access vector table
    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      case (v.op)
        OP_HW, OP_HR: begin
          host_op(v.op == OP_HW, v.addr, v.data, lat, rd, err);
          check($sformatf("v%0d host latency", i), 32'(lat), 32'd2);
          check($sformatf("v%0d host_err", i), 32'(err), 32'(v.exp_err));
          if (v.op == OP_HR) check($sformatf("v%0d host_rdata", i), 32'(rd), 32'(v.exp_dat));
        end
        OP_IW: begin
          i2c_wr(v.addr, v.data, upd, ua);
          check($sformatf("v%0d upd_valid", i), 32'(upd), 32'(v.exp_upd));
          if (v.exp_upd) check($sformatf("v%0d upd_addr", i), 32'(ua), 32'(v.addr));
        end
        default: begin
          i2c_rd(v.addr, rd);
          check($sformatf("v%0d i2c_rdata", i), 32'(rd), 32'(v.exp_dat));
        end
      endcase
    end

    // transfer with a committed write: xfer_done one cycle after i2c_done rises, dirty set
    @(negedge clk);
    bus.i2c_busy = 1'b1;
    i2c_wr(8'h04, 16'h4444, upd, ua);
    check("xferA upd_valid", 32'(upd), 32'h1);
    @(negedge clk);
    bus.i2c_busy = 1'b0;
    bus.i2c_done = 1'b1;
    check("xferA done early", 32'(bus.xfer_done), 32'h0);
    @(negedge clk);
    check("xferA xfer_done", 32'(bus.xfer_done), 32'h1);
    check("xferA xfer_dirty", 32'(bus.xfer_dirty), 32'h1);
    @(negedge clk);
    check("xferA done pulse width", 32'(bus.xfer_done), 32'h0);
    bus.i2c_done = 1'b0;

    // write outside a transfer, busy rise clears dirty, RO write dropped -> clean transfer
    i2c_wr(8'h08, 16'h0808, upd, ua);
    check("xferB pre-write upd", 32'(upd), 32'h1);
    @(negedge clk);
    bus.i2c_busy = 1'b1;
    i2c_wr(8'h00, 16'hDEAD, upd, ua);
    check("xferB RO upd_valid", 32'(upd), 32'h0);
    @(negedge clk);
    bus.i2c_busy = 1'b0;
    bus.i2c_done = 1'b1;
    @(negedge clk);
    check("xferB xfer_done", 32'(bus.xfer_done), 32'h1);
    check("xferB xfer_dirty", 32'(bus.xfer_dirty), 32'h0);
    bus.i2c_done = 1'b0;
    i2c_rd(8'h00, rd);
    check("xferB RO reg kept", 32'(rd), 32'h1234);

    // collision: i2c write 0x05 during host ACCESS of 0x05 defers host by one cycle
    @(negedge clk);
    bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 8'h05; bus.host_wdata = 16'h2222;
    @(negedge clk);
    check("coll ack c1", 32'(bus.host_ack), 32'h0);
    bus.i2c_write_en = 1'b1; bus.i2c_reg_addr = 8'h05; bus.i2c_wdata = 16'h1111;
    @(negedge clk);
    bus.i2c_write_en = 1'b0;
    check("coll ack c2", 32'(bus.host_ack), 32'h0);
    check("coll i2c upd_valid", 32'(bus.upd_valid), 32'h1);
    check("coll i2c upd_addr", 32'(bus.upd_addr), 32'h05);
    wait_ack(2, lat, rd, err);
    check("coll host latency", 32'(lat), 32'd3);
    check("coll host_err", 32'(err), 32'h0);
    host_op(1'b0, 8'h05, 16'h0, lat, rd, err);
    check("coll final reg host", 32'(rd), 32'h2222);
    i2c_rd(8'h05, rd);
    check("coll final reg i2c", 32'(rd), 32'h2222);

    // lock: host write waits while busy, acks 2 cycles after busy falls
    @(negedge clk);
    bus.i2c_busy = 1'b1;
    @(negedge clk);
    bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 8'h01; bus.host_wdata = 16'hAAAA;
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus.host_ack) seen = 1'b1;
    end
    check("lock no ack while busy", 32'(seen), 32'h0);
    bus.i2c_busy = 1'b0;
    wait_ack(0, lat, rd, err);
    check("lock latency after busy fall", 32'(lat), 32'd2);
    check("lock host_err", 32'(err), 32'h0);
    host_op(1'b0, 8'h01, 16'h0, lat, rd, err);
    check("lock reg value", 32'(rd), 32'hAAAA);

    // lock timeout: busy held, ack+err after 9 LOCKED cycles, register untouched
    @(negedge clk);
    bus.i2c_busy = 1'b1;
    host_op(1'b1, 8'h06, 16'h7777, lat, rd, err);
    check("tmo latency", 32'(lat), 32'd10);
    check("tmo host_err", 32'(err), 32'h1);
    host_op(1'b0, 8'h02, 16'h0, lat, rd, err);
    check("busy read latency", 32'(lat), 32'd2);
    check("busy read data", 32'(rd), 32'hBEEF);
    host_op(1'b0, 8'h06, 16'h0, lat, rd, err);
    check("tmo reg unchanged", 32'(rd), 32'h0000);
    @(negedge clk);
    bus.i2c_busy = 1'b0;

    // reset in the middle of a host access: no ack, registers cleared
    @(negedge clk);
    bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 8'h02;
    @(negedge clk);
    reset = 1'b0;
    bus.host_req = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (bus.host_ack) seen = 1'b1;
      if (k == 1) reset = 1'b1;
    end
    check("midrst no ack", 32'(seen), 32'h0);
    host_op(1'b0, 8'h02, 16'h0, lat, rd, err);
    check("midrst read latency", 32'(lat), 32'd2);
    check("midrst reg cleared", 32'(rd), 32'h0000);
    i2c_rd(8'h07, rd);
    check("midrst i2c reg cleared", 32'(rd), 32'h0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
